// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 32-bit integer divider (RISC-V M: DIV/DIVU/REM/REMU)
//
// A request is taken on a rising CLK edge with START=1 while idle. The
// unit then performs one restoring shift-subtract step per edge for 32
// edges. It registers the sign-corrected result on the following edge.
// Latency from the START edge to DONE is therefore 33 edges.
//
// Ports:
//   CLK     in   1   rising-edge clock
//   RESET   in   1   synchronous active-high reset (beats FLUSH and START)
//   START   in   1   request strobe, only looked at while idle
//   OP      in   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DATA1   in  32   dividend, captured with START
//   DATA2   in  32   divisor, captured with START
//   FLUSH   in   1   kill the operation in flight / block START while idle
//   BUSY    out  1   operation in progress
//   DONE    out  1   one-cycle pulse, RESULT valid
//   RESULT  out 32   registered quotient or remainder, held until next DONE
//
// Build option:
//   DIV_FAST_PATH_EN -- when defined, two kinds of request skip the
//                       iterations and go straight to the result state,
//                       so DONE follows one edge after START:
//                       - divide-by-zero requests
//                       - signed-overflow requests
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  r_op;
  logic [31:0] r_data1;
  logic [31:0] r_data2;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_quo;      // dividend magnitude shifts out, quotient shifts in
  logic [31:0] r_rem;      // partial remainder, always < divisor magnitude
  logic [31:0] r_dvs;      // divisor magnitude
  logic [4:0]  r_cnt;
  logic        r_done;
  logic [31:0] r_result;

  logic        w_signed;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic        w_accept;
  logic        w_special;
  logic        w_commit;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic        w_div_zero;
  logic        w_ovf;
  logic [31:0] w_fin_value;

  // DIV and REM (OP[0]=0) are the signed operations.
  assign w_signed = ~OP[0];
  assign w_abs1   = (w_signed && DATA1[31]) ? (32'd0 - DATA1) : DATA1;
  assign w_abs2   = (w_signed && DATA2[31]) ? (32'd0 - DATA2) : DATA2;
  assign w_accept = (r_state == S_IDLE) && START && !FLUSH;

`ifdef DIV_FAST_PATH_EN
  assign w_special = (DATA2 == 32'd0) ||
                     (w_signed && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF));
`else
  assign w_special = 1'b0;
`endif

  // Restoring step. Because r_rem < r_dvs, the shifted value is below
  // 2*r_dvs. Bit 32 of the difference is therefore a clean borrow flag.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[32];

  assign w_q_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_r_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

  // The special cases are resolved from the captured operands. Doing so
  // keeps the result correct even when the fast path skipped the iterations.
  assign w_div_zero = (r_data2 == 32'd0);
  assign w_ovf      = ~r_op[0] && (r_data1 == 32'h8000_0000) && (r_data2 == 32'hFFFF_FFFF);

  always_comb begin
    w_fin_value = 32'd0;
    if (w_div_zero)
      w_fin_value = r_op[1] ? r_data1 : 32'hFFFF_FFFF;
    else if (w_ovf)
      w_fin_value = r_op[1] ? 32'd0 : 32'h8000_0000;
    else
      w_fin_value = r_op[1] ? w_r_fix : w_q_fix;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_special ? S_FIN : S_CALC;
      S_CALC: begin
        if (FLUSH)
          w_state_next = S_IDLE;
        else if (r_cnt == 5'd31)
          w_state_next = S_FIN;
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY     = (r_state != S_IDLE);
    DONE     = r_done;
    RESULT   = r_result;
    // A flush in the result state drops the result entirely.
    w_commit = (r_state == S_FIN) && !FLUSH;
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_op     <= 2'd0;
      r_data1  <= 32'd0;
      r_data2  <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_dvs    <= 32'd0;
      r_cnt    <= 5'd0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= w_commit;
      if (w_commit)
        r_result <= w_fin_value;

      if (w_accept) begin
        r_op    <= OP;
        r_data1 <= DATA1;
        r_data2 <= DATA2;
        r_neg_q <= w_signed && (DATA1[31] ^ DATA2[31]);
        r_neg_r <= w_signed && DATA1[31];
        r_quo   <= w_abs1;
        r_dvs   <= w_abs2;
        r_rem   <= 32'd0;
        r_cnt   <= 5'd0;
      end else if (r_state == S_CALC) begin
        r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
        r_quo <= {r_quo[30:0], w_ge};
        r_cnt <= r_cnt + 5'd1;
      end
    end
  end

endmodule
